pong_renderer_pipe: RTL and testbench
=====================================

Name: pong_renderer_pipe

Overview:
Pipelined, parametrised successor of the combinational Pong pixel renderer. Takes a per-pixel (x, y) stream with valid, plus object positions, and produces a 24-bit RGB colour two cycles later. Object positions are latched once per frame into shadow registers, so the picture does not tear mid-frame. Adds a dashed centre net, out-of-screen blanking, and a frame-counted ball flash mode for score events. Sits between the VGA timing generator and the pixel output stage.

Parameters:
COORD_W, 10, width of all coordinates
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BALL_SIZE, 8, ball square side
PAD_W, 8, paddle width
PAD_H, 64, paddle height
PAD_MARGIN, 16, gap between each paddle's outer edge and the screen edge
NET_W, 4, centre net width
NET_DASH_LOG2, 3, log2 of net dash length (dash period is 2x this length)
FLASH_FRAMES, 4, flash duration in frames
BG_COLOR, 24'h000000, background colour
BALL_COLOR, 24'hFFFFFF, ball colour
PADDLE_COLOR, 24'h00FF00, paddle colour
NET_COLOR, 24'h808080, net colour

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  x/y valid this cycle
x  in  COORD_W  pixel column
y  in  COORD_W  pixel row
frame_start  in  1  one-cycle pulse with the first pixel of a frame
ball_x  in  COORD_W  ball top-left column
ball_y  in  COORD_W  ball top-left row
paddleL_y  in  COORD_W  left paddle top row
paddleR_y  in  COORD_W  right paddle top row
flash_req  in  1  one-cycle pulse that starts a ball flash
out_valid  out  1  pix_valid delayed 2 cycles
out_color  out  24  pixel colour, 0 when out_valid=0
flash_active  out  1  flash counter non-zero

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: out_valid=0, out_color=0, flash_active=0. Shadow positions=0, flash counter=0, and all pipeline registers=0.
- Shadow registers: updated from the inputs at the clock edge of any cycle where frame_start=1. The pixel presented in the frame_start cycle is compared against the new input values (bypass mux), not the old shadow values. Without frame_start, input changes have no effect.
- Pipeline, always advancing, no stall:
  - Stage 1 registers the hit flags: ball, paddleL, paddleR, net, offscreen.
  - Stage 2 registers the priority-muxed colour.
  - Latency is exactly 2 cycles, and out_valid is pix_valid delayed 2 cycles.
- Hit rules. All additions are done at COORD_W+1 bits, so there is no wrap-around.
  - Ball: ball_x <= x < ball_x+BALL_SIZE and ball_y <= y < ball_y+BALL_SIZE.
  - PaddleL: PAD_MARGIN <= x < PAD_MARGIN+PAD_W, paddleL_y <= y < paddleL_y+PAD_H.
  - PaddleR: H_RES-PAD_MARGIN-PAD_W <= x < H_RES-PAD_MARGIN, same y rule using paddleR_y.
  - Net: H_RES/2-NET_W/2 <= x < H_RES/2-NET_W/2+NET_W, and y[NET_DASH_LOG2]==0.
  - Offscreen: x >= H_RES or y >= V_RES.
- Colour priority, highest first:
  1. Offscreen gives 24'h000000.
  2. Ball (if not hidden) gives BALL_COLOR.
  3. Either paddle gives PADDLE_COLOR.
  4. Net gives NET_COLOR.
  5. Otherwise BG_COLOR.
- Flash counter:
  - Width is $clog2(FLASH_FRAMES+1).
  - flash_req loads FLASH_FRAMES.
  - Otherwise frame_start decrements it when non-zero.
  - If flash_req and frame_start arrive in the same cycle, the load wins.
  - The ball is hidden while counter[0]==1, and the hide decision is sampled in stage 1.
  - flash_active = (counter != 0), registered.
- Reset mid-frame clears everything immediately; output stays invalid until new pix_valid has passed through the pipeline.

Decomposition:
- Package pong_pkg holds:
  - RGB_W=24;
  - the default colour constants;
  - a hit_t packed struct (ball, padL, padR, net, off).
- Sub-module pong_rect_hit is a combinational point-in-rectangle test, parametrised by COORD_W, with inputs x, y, rx, ry, w, h. It is instantiated three times: ball, left paddle, right paddle.

Test Plan:
1. Reset: hold rst_n=0 with pix_valid=1. Required: out_valid=0, out_color=0, flash_active=0. After release, out_valid rises exactly 2 cycles after the first pix_valid.
2. Basic render: frame_start with ball=(10,20), paddleL_y=100, paddleR_y=200, then pixels (12,22), (300,300), (20,130), (320,0) and (320,8). Required colours 2 cycles later, in order: FFFFFF, 000000, 00FF00, 808080, 000000.
3. Shadow latch: in the frame from test 2, set ball_x=200 with no frame_start; pixel (12,22) still gives FFFFFF. Then pulse frame_start; pixel (12,22) gives 000000 and (202,22) gives FFFFFF.
4. Priority and edges: with ball=(18,110) and paddleL_y=100, pixel (20,112) gives FFFFFF. With ball_x=636, pixel (639,y) is ball-coloured, (4,y) is not ball, and pixel x=700 gives 000000.
5. Flash: flash_req, then 5 frame_starts, checking ball pixel (12,22) in each frame. Counter runs 4,3,2,1,0, so the colours are FFFFFF, 000000, FFFFFF, 000000, FFFFFF. flash_active=1 for the first four frames and 0 in the last.
6. Collision of events: flash_req and frame_start in the same cycle while the counter is 1. Required: counter becomes 4 and flash_active stays 1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default colours for the Pong pixel renderer.
package pong_pkg;
  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] DEF_BG_COLOR     = 24'h000000;
  localparam logic [RGB_W-1:0] DEF_BALL_COLOR   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] DEF_PADDLE_COLOR = 24'h00FF00;
  localparam logic [RGB_W-1:0] DEF_NET_COLOR    = 24'h808080;
  localparam logic [RGB_W-1:0] OFF_COLOR        = 24'h000000;

  typedef struct packed {
    logic ball;
    logic pad_l;
    logic pad_r;
    logic net;
    logic off;
  } hit_t;
endpackage

// File: rtl/pong_rect_hit.sv
// Combinational point-in-rectangle test; edge sums use one extra bit so they never wrap.
module pong_rect_hit #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic               hit
);
  logic [COORD_W:0] x_end, y_end;

  assign x_end = {1'b0, rx} + {1'b0, w};
  assign y_end = {1'b0, ry} + {1'b0, h};
  assign hit   = (x >= rx) && ({1'b0, x} < x_end) &&
                 (y >= ry) && ({1'b0, y} < y_end);
endmodule

// File: rtl/pong_renderer_pipe.sv
// Two-stage Pong pixel renderer: stage 1 registers hit flags, stage 2 the priority colour.
module pong_renderer_pipe
  import pong_pkg::*;
#(
  parameter int                COORD_W       = 10,
  parameter int                H_RES         = 640,
  parameter int                V_RES         = 480,
  parameter int                BALL_SIZE     = 8,
  parameter int                PAD_W         = 8,
  parameter int                PAD_H         = 64,
  parameter int                PAD_MARGIN    = 16,
  parameter int                NET_W         = 4,
  parameter int                NET_DASH_LOG2 = 3,
  parameter int                FLASH_FRAMES  = 4,
  parameter logic [RGB_W-1:0]  BG_COLOR      = DEF_BG_COLOR,
  parameter logic [RGB_W-1:0]  BALL_COLOR    = DEF_BALL_COLOR,
  parameter logic [RGB_W-1:0]  PADDLE_COLOR  = DEF_PADDLE_COLOR,
  parameter logic [RGB_W-1:0]  NET_COLOR     = DEF_NET_COLOR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddleL_y,
  input  logic [COORD_W-1:0] paddleR_y,
  input  logic               flash_req,
  output logic               out_valid,
  output logic [RGB_W-1:0]   out_color,
  output logic               flash_active
);
  localparam int STAGES = 2;
  localparam int FW     = $clog2(FLASH_FRAMES + 1);
  localparam int NET_X0 = H_RES / 2 - NET_W / 2;
  localparam int PADR_X = H_RES - PAD_MARGIN - PAD_W;

  logic [COORD_W-1:0] sh_bx, sh_by, sh_pl, sh_pr;
  logic [COORD_W-1:0] eff_bx, eff_by, eff_pl, eff_pr;
  logic [COORD_W:0]   x1, y1;
  logic [FW-1:0]      cnt, cnt_nxt;
  logic [STAGES:1]    vld_pipe;
  logic               ball_hit, padl_hit, padr_hit;
  hit_t               hit_d, hit_q;
  logic [RGB_W-1:0]   col_d;

  // The frame_start pixel already sees the new positions.
  assign eff_bx = frame_start ? ball_x    : sh_bx;
  assign eff_by = frame_start ? ball_y    : sh_by;
  assign eff_pl = frame_start ? paddleL_y : sh_pl;
  assign eff_pr = frame_start ? paddleR_y : sh_pr;

  assign x1 = {1'b0, x};
  assign y1 = {1'b0, y};

  pong_rect_hit #(.COORD_W(COORD_W)) u_ball (
    .x(x), .y(y), .rx(eff_bx), .ry(eff_by),
    .w(COORD_W'(BALL_SIZE)), .h(COORD_W'(BALL_SIZE)), .hit(ball_hit)
  );
  pong_rect_hit #(.COORD_W(COORD_W)) u_pad_l (
    .x(x), .y(y), .rx(COORD_W'(PAD_MARGIN)), .ry(eff_pl),
    .w(COORD_W'(PAD_W)), .h(COORD_W'(PAD_H)), .hit(padl_hit)
  );
  pong_rect_hit #(.COORD_W(COORD_W)) u_pad_r (
    .x(x), .y(y), .rx(COORD_W'(PADR_X)), .ry(eff_pr),
    .w(COORD_W'(PAD_W)), .h(COORD_W'(PAD_H)), .hit(padr_hit)
  );

  always_comb begin
    hit_d       = '0;
    hit_d.ball  = ball_hit && !cnt[0];
    hit_d.pad_l = padl_hit;
    hit_d.pad_r = padr_hit;
    hit_d.net   = (x1 >= (COORD_W+1)'(NET_X0)) && (x1 < (COORD_W+1)'(NET_X0 + NET_W)) &&
                  !y[NET_DASH_LOG2];
    hit_d.off   = (x1 >= (COORD_W+1)'(H_RES)) || (y1 >= (COORD_W+1)'(V_RES));
  end

  // A flash request overrides the per-frame decrement.
  always_comb begin
    cnt_nxt = cnt;
    if (flash_req)                     cnt_nxt = FW'(FLASH_FRAMES);
    else if (frame_start && cnt != '0) cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    col_d = BG_COLOR;
    if (hit_q.off)                     col_d = OFF_COLOR;
    else if (hit_q.ball)               col_d = BALL_COLOR;
    else if (hit_q.pad_l || hit_q.pad_r) col_d = PADDLE_COLOR;
    else if (hit_q.net)                col_d = NET_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bx        <= '0;
      sh_by        <= '0;
      sh_pl        <= '0;
      sh_pr        <= '0;
      cnt          <= '0;
      flash_active <= 1'b0;
      vld_pipe     <= '0;
      hit_q        <= '0;
      out_color    <= '0;
    end else begin
      if (frame_start) begin
        sh_bx <= ball_x;
        sh_by <= ball_y;
        sh_pl <= paddleL_y;
        sh_pr <= paddleR_y;
      end
      cnt          <= cnt_nxt;
      flash_active <= (cnt_nxt != '0);
      vld_pipe     <= {vld_pipe[STAGES-1:1], pix_valid};
      hit_q        <= hit_d;
      out_color    <= vld_pipe[1] ? col_d : '0;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_pong_renderer_pipe.sv
// Directed and randomized checks of pong_renderer_pipe against a frame-level reference model.
module tb_pong_renderer_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  ball_x = '0, ball_y = '0, paddleL_y = '0, paddleR_y = '0;
  logic        flash_req = 1'b0;
  logic        out_valid;
  logic [23:0] out_color;
  logic        flash_active;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: latched positions, flash count, and outputs still in flight.
  int          m_bx, m_by, m_pl, m_pr, m_cnt;
  logic        qv[$];
  logic [23:0] qc[$];

  always #5 clk = ~clk;

  pong_renderer_pipe dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y),
    .frame_start(frame_start), .ball_x(ball_x), .ball_y(ball_y),
    .paddleL_y(paddleL_y), .paddleR_y(paddleR_y), .flash_req(flash_req),
    .out_valid(out_valid), .out_color(out_color), .flash_active(flash_active)
  );

  function automatic logic [23:0] ref_col(int px, int py, int bx, int by, int pl, int pr,
                                          bit hide);
    if (px >= 640 || py >= 480) return 24'h000000;
    if (!hide && px >= bx && px < bx + 8 && py >= by && py < by + 8) return 24'hFFFFFF;
    if ((px >= 16 && px < 24 && py >= pl && py < pl + 64) ||
        (px >= 616 && px < 624 && py >= pr && py < pr + 64)) return 24'h00FF00;
    if (px >= 318 && px < 322 && ((py / 8) % 2 == 0)) return 24'h808080;
    return 24'h000000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_pl = 0; m_pr = 0; m_cnt = 0;
    qv.delete(); qc.delete();
    qv.push_back(1'b0); qc.push_back(24'h0);
  endtask

  // One clock: drive inputs, predict, then compare the output due this cycle.
  task automatic step(input logic pv, input int px, input int py, input logic fs,
                      input logic fr);
    int bx, by, pl, pr;
    pix_valid = pv; x = 10'(px); y = 10'(py); frame_start = fs; flash_req = fr;
    bx = fs ? int'(ball_x) : m_bx;
    by = fs ? int'(ball_y) : m_by;
    pl = fs ? int'(paddleL_y) : m_pl;
    pr = fs ? int'(paddleR_y) : m_pr;
    qv.push_back(pv);
    qc.push_back(pv ? ref_col(px, py, bx, by, pl, pr, m_cnt % 2 == 1) : 24'h0);
    @(posedge clk);
    if (fs) begin m_bx = bx; m_by = by; m_pl = pl; m_pr = pr; end
    if (fr) m_cnt = 4;
    else if (fs && m_cnt > 0) m_cnt = m_cnt - 1;
    #1;
    pix_valid = 1'b0; frame_start = 1'b0; flash_req = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(qv.pop_front()));
    chk("out_color", 32'(out_color), 32'(qc.pop_front()));
    chk("flash_active", 32'(flash_active), 32'(m_cnt != 0));
  endtask

  task automatic pix(input int px, input int py, input logic fs, input logic [23:0] e,
                     input string tag);
    step(1'b1, px, py, fs, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    chk(tag, 32'(out_color), 32'(e));
  endtask

  initial begin
    logic [23:0] flash_col[5];
    logic        flash_act[5];
    flash_col = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    flash_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with pixels streaming in
    pix_valid = 1'b1; x = 10'd5; y = 10'd5;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_color", 32'(out_color), 32'd0);
      chk("rst_flash", 32'(flash_active), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 5, 5, 1'b0, 1'b0);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    step(1'b1, 5, 5, 1'b0, 1'b0);
    chk("lat_2cyc", 32'(out_valid), 32'd1);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);

    // Basic render
    ball_x = 10; ball_y = 20; paddleL_y = 100; paddleR_y = 200;
    pix(12, 22, 1'b1, 24'hFFFFFF, "basic_ball_bypass");
    pix(300, 300, 1'b0, 24'h000000, "basic_bg");
    pix(20, 130, 1'b0, 24'h00FF00, "basic_paddle");
    pix(320, 0, 1'b0, 24'h808080, "basic_net");
    pix(320, 8, 1'b0, 24'h000000, "basic_net_gap");

    // Shadow latch
    ball_x = 200;
    pix(12, 22, 1'b0, 24'hFFFFFF, "shadow_hold");
    pix(12, 22, 1'b1, 24'h000000, "shadow_new_old_pos");
    pix(202, 22, 1'b0, 24'hFFFFFF, "shadow_new_pos");

    // Priority and edges
    ball_x = 18; ball_y = 110; paddleL_y = 100;
    pix(20, 112, 1'b1, 24'hFFFFFF, "prio_ball_over_paddle");
    ball_x = 636;
    pix(639, 112, 1'b1, 24'hFFFFFF, "edge_ball_right");
    pix(4, 112, 1'b0, 24'h000000, "edge_no_wrap");
    pix(700, 112, 1'b0, 24'h000000, "edge_offscreen");

    // Flash sequence
    ball_x = 10; ball_y = 20;
    step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pix(12, 22, 1'b0, flash_col[i], "flash_color");
      chk("flash_active_seq", 32'(flash_active), 32'(flash_act[i]));
      step(1'b0, 0, 0, 1'b1, 1'b0);
    end

    // Load wins over decrement
    step(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 0, 0, 1'b1, 1'b0);
    pix(12, 22, 1'b0, 24'h000000, "collide_cnt1_hidden");
    step(1'b0, 0, 0, 1'b1, 1'b1);
    chk("collide_active", 32'(flash_active), 32'd1);
    pix(12, 22, 1'b0, 24'hFFFFFF, "collide_cnt4_visible");
    step(1'b0, 0, 0, 1'b1, 1'b0);
    pix(12, 22, 1'b0, 24'h000000, "collide_cnt3_hidden");

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int px, py;
      if ($urandom_range(0, 9) == 0) begin
        ball_x = 10'($urandom_range(0, 660));
        ball_y = 10'($urandom_range(0, 490));
        paddleL_y = 10'($urandom_range(0, 480));
        paddleR_y = 10'($urandom_range(0, 480));
      end
      if ($urandom_range(0, 1) == 0) begin
        px = (ball_x > 4) ? int'(ball_x) - 4 + int'($urandom_range(0, 14)) : int'($urandom_range(0, 14));
        py = (ball_y > 4) ? int'(ball_y) - 4 + int'($urandom_range(0, 14)) : int'($urandom_range(0, 14));
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      step(1'($urandom_range(0, 3) != 0), px, py,
           1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 40) == 0));
    end

    // Mid-stream reset
    pix_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_flash", 32'(flash_active), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    pix(12, 22, 1'b0, 24'h000000, "post_rst_shadow_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
